// File: rtl/maxpool_pkg.sv
// ============================================================================
// maxpool_pkg : shared types, default geometry and compare helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package maxpool_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CHANNELS   = 3;
    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;

    localparam int OUT_W    = DEF_IMG_WIDTH / 2;
    localparam int OUT_H    = DEF_IMG_HEIGHT / 2;
    localparam int COL_BITS = $clog2(DEF_IMG_WIDTH);
    localparam int ROW_BITS = $clog2(DEF_IMG_HEIGHT);

    // Operands are zero-extended to this width so one helper serves any DATA_WIDTH <= 32.
    localparam int MAXU_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic logic [MAXU_W-1:0] max_u(input logic [MAXU_W-1:0] a,
                                                input logic [MAXU_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/maxpool_line_buf.sv
// ============================================================================
// maxpool_line_buf : one row of horizontal maxima, sync write / async read
// Revision         : 1.0
// ============================================================================
`default_nettype none

module maxpool_line_buf #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/maxpool_stream.sv
// ============================================================================
// maxpool_stream : 2x2 stride-2 per-channel max pooling on a raster stream
// Revision       : 1.0
// ============================================================================
`default_nettype none

module maxpool_stream
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pixel_in,
    input  logic                           pixel_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] pool_out,
    output logic                           pool_valid,
    output logic                           frame_done
);

    localparam int c_PW       = CHANNELS * DATA_WIDTH;
    localparam int c_OUT_W    = IMG_WIDTH / 2;
    localparam int c_OUT_H    = IMG_HEIGHT / 2;
    localparam int c_COL_BITS = $clog2(IMG_WIDTH);
    localparam int c_ROW_BITS = $clog2(IMG_HEIGHT);
    localparam int c_AW       = c_COL_BITS - 1;

    localparam logic [c_COL_BITS-1:0] c_COL_LAST = c_COL_BITS'(IMG_WIDTH - 1);
    localparam logic [c_ROW_BITS-1:0] c_ROW_LAST = c_ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [c_COL_BITS-1:0] c_COL_DONE = c_COL_BITS'(2 * c_OUT_W - 1);
    localparam logic [c_ROW_BITS-1:0] c_ROW_DONE = c_ROW_BITS'(2 * c_OUT_H - 1);

    state_e                  state_q, state_d;
    logic [c_COL_BITS-1:0]   col_q, col_d;
    logic [c_ROW_BITS-1:0]   row_q, row_d;
    logic [c_PW-1:0]         h_q, h_d;
    logic [c_PW-1:0]         pool_out_q, pool_out_d;
    logic                    pool_valid_q, pool_valid_d;
    logic                    frame_done_q, frame_done_d;

    logic                    w_accept;
    logic [c_COL_BITS-1:0]   w_col;
    logic [c_ROW_BITS-1:0]   w_row;
    logic [c_PW-1:0]         w_hmax;
    logic [c_PW-1:0]         w_pool;
    logic [c_PW-1:0]         w_lb_rd;
    logic                    w_lb_we;

    // frame_start overrides the counters so a coincident pixel lands at (0,0).
    always_comb begin
        w_accept = pixel_valid && (frame_start || (state_q == ACTIVE));
        w_col    = frame_start ? '0 : col_q;
        w_row    = frame_start ? '0 : row_q;
        w_hmax   = '0;
        w_pool   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_hmax[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(max_u(
                MAXU_W'(h_q[c*DATA_WIDTH +: DATA_WIDTH]),
                MAXU_W'(pixel_in[c*DATA_WIDTH +: DATA_WIDTH])));
        end
        for (int c = 0; c < CHANNELS; c++) begin
            w_pool[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(max_u(
                MAXU_W'(w_lb_rd[c*DATA_WIDTH +: DATA_WIDTH]),
                MAXU_W'(w_hmax[c*DATA_WIDTH +: DATA_WIDTH])));
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        pool_out_d   = pool_out_q;
        pool_valid_d = 1'b0;
        frame_done_d = 1'b0;
        w_lb_we      = 1'b0;

        if (frame_start) begin
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
        end

        if (w_accept) begin
            if (!w_col[0]) begin
                h_d = pixel_in;
            end else if (!w_row[0]) begin
                // A trailing unpaired row (odd height) never reaches the line buffer.
                w_lb_we = (w_row != c_ROW_LAST);
            end else begin
                pool_out_d   = w_pool;
                pool_valid_d = 1'b1;
                frame_done_d = (w_row == c_ROW_DONE) && (w_col == c_COL_DONE);
            end

            if (w_col == c_COL_LAST) begin
                col_d = '0;
                if (w_row == c_ROW_LAST) begin
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    row_d = w_row + 1'b1;
                end
            end else begin
                col_d = w_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            pool_out_q   <= '0;
            pool_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            pool_out_q   <= pool_out_d;
            pool_valid_q <= pool_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    maxpool_line_buf #(
        .WIDTH (c_PW),
        .DEPTH (c_OUT_W),
        .AW    (c_AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (w_lb_we),
        .addr_i  (w_col[c_COL_BITS-1:1]),
        .wdata_i (w_hmax),
        .rdata_o (w_lb_rd)
    );

    assign pool_out   = pool_out_q;
    assign pool_valid = pool_valid_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_stream.sv
// ============================================================================
// tb_maxpool_stream : randomized self-checking bench against a window-max model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_maxpool_stream;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int OW = W / 2;
    localparam int OH = H / 2;
    localparam int PW = DW * CH;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [PW-1:0] pixel_in;
    logic          pixel_valid;
    logic [PW-1:0] pool_out;
    logic          pool_valid;
    logic          frame_done;

    always #5 clk = ~clk;

    maxpool_stream #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pool_out    (pool_out),
        .pool_valid  (pool_valid),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [PW-1:0] val;
        logic          done;
        longint        due;
    } exp_t;

    exp_t          exp_q[$];
    logic [PW-1:0] img [H][W];
    logic [PW-1:0] last_out = '0;
    longint        cyc      = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_out    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: per-channel maximum over the four pixels of window (i,j).
    function automatic logic [PW-1:0] window_max(input int i, input int j);
        logic [PW-1:0] res;
        int            best;
        int            v;
        res = '0;
        for (int ch = 0; ch < CH; ch++) begin
            best = 0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    v = int'(img[2*i+dy][2*j+dx][ch*DW +: DW]);
                    if (v > best) best = v;
                end
            end
            res[ch*DW +: DW] = DW'(best);
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic fill_ramp();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = pack3(y*W+x, y*W+x, y*W+x);
    endtask

    task automatic fill_indep();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = pack3(y*W+x, 255-(y*W+x), ((x+y)%2 == 1) ? 128 : 32);
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = PW'($urandom);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                last_out = '0;
            end else if (pool_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pool_valid", 64'(pool_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pool_out", 64'(pool_out), 64'(e.val));
                    chk("frame_done", 64'(frame_done), 64'(e.done));
                    chk("latency_cycle", 64'(cyc), 64'(e.due));
                    last_out = e.val;
                end
            end else begin
                chk("frame_done_without_valid", 64'(frame_done), 64'(0));
                chk("pool_out_hold", 64'(pool_out), 64'(last_out));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            frame_start = 1'b0;
            pixel_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // Sends pixels in raster order up to and including (stop_r, stop_c).
    task automatic send_frame(input int duty, input bit fs_with_pix, input int stop_r, input int stop_c);
        if (!fs_with_pix) begin
            frame_start = 1'b1;
            pixel_valid = 1'b0;
            pixel_in    = PW'($urandom);
            @(negedge clk);
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r*W + c <= stop_r*W + stop_c) begin
                    while (!(fs_with_pix && r == 0 && c == 0) && ($urandom_range(99) >= duty)) begin
                        frame_start = 1'b0;
                        pixel_valid = 1'b0;
                        pixel_in    = PW'($urandom);
                        @(negedge clk);
                    end
                    frame_start = fs_with_pix && (r == 0) && (c == 0);
                    pixel_valid = 1'b1;
                    pixel_in    = img[r][c];
                    if ((r % 2 == 1) && (c % 2 == 1))
                        exp_q.push_back('{val: window_max(r/2, c/2),
                                          done: (r/2 == OH-1) && (c/2 == OW-1),
                                          due: cyc + 1});
                    @(negedge clk);
                end
            end
        end
        frame_start = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int n_before, input int n_expected);
        idle(4);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_output_count"}, 64'(n_out - n_before), 64'(n_expected));
    endtask

    initial begin : stimulus
        int base;
        rst         = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        repeat (3) @(negedge clk);
        chk("reset_pool_out", 64'(pool_out), 64'(0));
        chk("reset_pool_valid", 64'(pool_valid), 64'(0));
        chk("reset_frame_done", 64'(frame_done), 64'(0));
        rst = 1'b0;
        idle(2);

        fill_ramp();
        chk("model_ramp_first", 64'(window_max(0, 0)), 64'(pack3(9, 9, 9)));
        chk("model_ramp_last", 64'(window_max(OH-1, OW-1)), 64'(pack3(63, 63, 63)));
        base = n_out;
        send_frame(100, 1'b0, H-1, W-1);
        drain("ramp", base, OH*OW);

        fill_indep();
        chk("model_indep_first", 64'(window_max(0, 0)), 64'(pack3(9, 255, 128)));
        chk("model_indep_last", 64'(window_max(OH-1, OW-1)), 64'(pack3(63, 201, 128)));
        base = n_out;
        send_frame(100, 1'b0, H-1, W-1);
        drain("indep", base, OH*OW);

        fill_ramp();
        base = n_out;
        send_frame(50, 1'b0, H-1, W-1);
        drain("ramp_gaps", base, OH*OW);

        repeat (10) begin
            frame_start = 1'b0;
            pixel_valid = 1'b1;
            pixel_in    = PW'($urandom);
            @(negedge clk);
        end
        pixel_valid = 1'b0;
        base = n_out;
        send_frame(100, 1'b1, H-1, W-1);
        drain("idle_then_fs_with_pixel", base, OH*OW);

        base = n_out;
        send_frame(100, 1'b0, 3, 4);
        send_frame(100, 1'b0, H-1, W-1);
        drain("abort_restart", base, 6 + OH*OW);

        base = n_out;
        send_frame(100, 1'b0, 3, 1);
        idle(1);
        rst = 1'b1;
        #1;
        chk("async_rst_pool_out", 64'(pool_out), 64'(0));
        chk("async_rst_pool_valid", 64'(pool_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send_frame(100, 1'b0, H-1, W-1);
        drain("after_reset", base, 5 + OH*OW);

        for (int f = 0; f < 3; f++) begin
            fill_random();
            base = n_out;
            send_frame(70, (f == 1), H-1, W-1);
            drain("random_frame", base, OH*OW);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
